// File: rtl/gpio_cmd_bridge.sv
// PS GPIO word to fabric register-bus bridge: synchronizes the strobe word, issues
// one-cycle write/trigger strobes and returns readback data with an ack toggle.
module gpio_cmd_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       gpio_in,
  output logic [31:0]       gpio_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              run_trig,
  output logic              del_trig,
  output logic              halt,
  output logic              adc_run,
  output logic [15:0]       txn_count
);
  localparam int STB = ADDR_W + DATA_W;
  localparam int SW  = STB + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } req_t;

  state_e            state_q, state_d;
  logic [SW-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic              s3_q, s3_d;
  logic [1:0]        sync_vld_q, sync_vld_d;
  logic              armed_q, armed_d;
  req_t              req_q, req_d, req_s2;
  logic              wr_en_q, wr_en_d;
  logic              run_q, run_d, del_q, del_d, halt_q, halt_d;
  logic              adc_q, adc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rdbk_q, rdbk_d;
  logic              ack_q, ack_d;
  logic              stb_rise;
  logic              unused_gpio;

  function automatic logic is_ro(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(6)  && a <= ADDR_W'(11)) ||
           (a >= ADDR_W'(18) && a <= ADDR_W'(20));
  endfunction

  assign unused_gpio = ^gpio_in[31:SW];
  assign req_s2      = req_t'(s2_q[STB-1:0]);
  // Only arm once s2 carries real pin data (two cycles after reset) and shows
  // the strobe low, so a strobe held high through reset is never taken as an edge.
  assign stb_rise    = armed_q & s2_q[STB] & ~s3_q;

  always_comb begin
    s1_d       = gpio_in[SW-1:0];
    s2_d       = s1_q;
    s3_d       = s2_q[STB];
    sync_vld_d = {sync_vld_q[0], 1'b1};
    armed_d    = armed_q | (sync_vld_q[1] & ~s2_q[STB]);
    state_d    = state_q;
    req_d      = req_q;
    wr_en_d    = 1'b0;
    run_d      = 1'b0;
    del_d      = 1'b0;
    halt_d     = 1'b0;
    adc_d      = adc_q;
    cnt_d      = cnt_q;
    rdbk_d     = rdbk_q;
    ack_d      = ack_q;
    case (state_q)
      IDLE: if (stb_rise) begin
        state_d = WRITE;
        req_d   = req_s2;
        cnt_d   = cnt_q + 16'd1;
        if (!is_ro(req_s2.addr)) begin
          wr_en_d = 1'b1;
          run_d   = (req_s2.addr == ADDR_W'(0));
          del_d   = (req_s2.addr == ADDR_W'(1));
          halt_d  = (req_s2.addr == ADDR_W'(2));
          if (req_s2.addr == ADDR_W'(5)) adc_d = req_s2.data[0];
        end
      end
      // rd_data is sampled while the write is on the bus, so the register file
      // must present post-write data combinationally.
      WRITE: begin
        state_d = READ;
        rdbk_d  = rd_data;
        ack_d   = ~ack_q;
      end
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= 1'b0;
      sync_vld_q <= '0;
      armed_q    <= 1'b0;
      req_q      <= '0;
      wr_en_q    <= 1'b0;
      run_q      <= 1'b0;
      del_q      <= 1'b0;
      halt_q     <= 1'b0;
      adc_q      <= 1'b0;
      cnt_q      <= '0;
      rdbk_q     <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      sync_vld_q <= sync_vld_d;
      armed_q    <= armed_d;
      req_q      <= req_d;
      wr_en_q    <= wr_en_d;
      run_q      <= run_d;
      del_q      <= del_d;
      halt_q     <= halt_d;
      adc_q      <= adc_d;
      cnt_q      <= cnt_d;
      rdbk_q     <= rdbk_d;
      ack_q      <= ack_d;
    end
  end

  assign gpio_out  = {{(31-DATA_W){1'b0}}, ack_q, rdbk_q};
  assign wr_en     = wr_en_q;
  assign wr_addr   = req_q.addr;
  assign wr_data   = req_q.data;
  assign rd_addr   = req_q.addr;
  assign run_trig  = run_q;
  assign del_trig  = del_q;
  assign halt      = halt_q;
  assign adc_run   = adc_q;
  assign txn_count = cnt_q;
endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// Randomized bench for gpio_cmd_bridge with a transaction-level reference model
// and a write-through register file model on rd_data.
module tb_gpio_cmd_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_in, gpio_out;
  logic        wr_en, run_trig, del_trig, halt, adc_run;
  logic [15:0] wr_addr, rd_addr, txn_count;
  logic [7:0]  wr_data, rd_data;

  int errors = 0;
  int checks = 0;

  gpio_cmd_bridge #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .run_trig(run_trig), .del_trig(del_trig), .halt(halt),
    .adc_run(adc_run), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Register file: writable storage plus fixed read-only values, bypassed on write.
  logic [7:0] wmem [0:65535];
  logic [7:0] ro_val [0:31];
  always @(posedge clk) if (wr_en) wmem[wr_addr] <= wr_data;
  assign rd_data = wr_en ? wr_data :
                   (is_ro(rd_addr) ? ro_val[rd_addr[4:0]] : wmem[rd_addr]);

  // Reference model state
  logic [15:0] m_count;
  logic        m_ack;
  logic [7:0]  m_rdbk;
  logic        m_adc;

  // Observations from the last transaction
  int          o_wr, o_run, o_del, o_halt;
  logic        o_e3wr, o_e3run, o_e3del, o_e3halt, o_adc;
  logic [15:0] o_addr, o_raddr, o_cnt;
  logic [7:0]  o_data;
  logic [31:0] o_gout;

  function automatic bit is_ro(input logic [15:0] a);
    return (a >= 16'd6 && a <= 16'd11) || (a >= 16'd18 && a <= 16'd20);
  endfunction

  function automatic logic [31:0] exp_gout();
    return {23'd0, m_ack, m_rdbk};
  endfunction

  task automatic model_reset();
    m_count = 16'd0; m_ack = 1'b0; m_rdbk = 8'd0; m_adc = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One PS transaction obeying the setup/strobe timing; records what the DUT did.
  task automatic drive_txn(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    gpio_in = {7'd0, 1'b0, d, a};
    repeat (3) @(negedge clk);
    gpio_in[24] = 1'b1;
    o_wr = 0; o_run = 0; o_del = 0; o_halt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      o_wr += int'(wr_en); o_run += int'(run_trig);
      o_del += int'(del_trig); o_halt += int'(halt);
      if (k == 3) begin
        o_e3wr = wr_en; o_e3run = run_trig; o_e3del = del_trig; o_e3halt = halt;
        o_addr = wr_addr; o_raddr = rd_addr; o_data = wr_data;
        o_adc = adc_run; o_cnt = txn_count;
      end
      if (k == 4) o_gout = gpio_out;
      if (k == 5) gpio_in[24] = 1'b0;
    end
    m_count = m_count + 16'd1;
    m_ack   = ~m_ack;
    m_rdbk  = is_ro(a) ? ro_val[a[4:0]] : d;
    if (!is_ro(a) && a == 16'd5) m_adc = d[0];
  endtask

  task automatic test_reset();
    gpio_in = 32'd0;
    do_reset(3);
    checks++; if (gpio_out !== 32'd0) begin errors++; $display("FAIL reset_gpio_out: got %h exp 0", gpio_out); end
    checks++; if ({wr_en, run_trig, del_trig, halt, adc_run} !== 5'd0) begin errors++;
      $display("FAIL reset_strobes: got %b exp 00000", {wr_en, run_trig, del_trig, halt, adc_run}); end
    checks++; if ({wr_addr, rd_addr, wr_data, txn_count} !== 56'd0) begin errors++;
      $display("FAIL reset_regs: got %h %h %h %h exp 0", wr_addr, rd_addr, wr_data, txn_count); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic_write();
    drive_txn(16'h000C, 8'hA5);
    checks++; if (o_wr !== 1 || o_e3wr !== 1'b1) begin errors++; $display("FAIL basic_wr_en: cycles %0d at_e3 %b exp 1 1", o_wr, o_e3wr); end
    checks++; if (o_addr !== 16'h000C || o_raddr !== 16'h000C || o_data !== 8'hA5) begin errors++;
      $display("FAIL basic_addr_data: got %h %h %h exp 000c 000c a5", o_addr, o_raddr, o_data); end
    checks++; if (o_gout !== 32'h0000_01A5) begin errors++; $display("FAIL basic_gpio_out: got %h exp 000001a5", o_gout); end
    checks++; if (o_cnt !== 16'd1) begin errors++; $display("FAIL basic_count: got %h exp 0001", o_cnt); end
  endtask

  task automatic test_pulses();
    for (int a = 0; a < 3; a++) begin
      drive_txn(16'(a), 8'($urandom));
      checks++; if ({o_e3run, o_e3del, o_e3halt} !== (3'b100 >> a) || o_e3wr !== 1'b1) begin errors++;
        $display("FAIL pulse_coincident a=%0d: got %b wr %b exp %b wr 1", a, {o_e3run, o_e3del, o_e3halt}, o_e3wr, 3'b100 >> a); end
      checks++; if (o_run + o_del + o_halt != 1 || o_wr != 1) begin errors++;
        $display("FAIL pulse_width a=%0d: got %0d/%0d/%0d wr %0d exp single", a, o_run, o_del, o_halt, o_wr); end
    end
  endtask

  task automatic test_adc_run();
    drive_txn(16'h0005, 8'h01);
    checks++; if (o_adc !== 1'b1 || o_e3wr !== 1'b1) begin errors++; $display("FAIL adc_rise: got %b wr %b exp 1 1", o_adc, o_e3wr); end
    drive_txn(16'h0005, 8'hFE);
    checks++; if (o_adc !== 1'b0 || o_e3wr !== 1'b1) begin errors++; $display("FAIL adc_fall: got %b wr %b exp 0 1", o_adc, o_e3wr); end
  endtask

  task automatic test_readonly();
    logic [15:0] bnd [8];
    bnd = '{16'd5, 16'd6, 16'd11, 16'd12, 16'd17, 16'd18, 16'd20, 16'd21};
    ro_val[7] = 8'h3C;
    drive_txn(16'h0007, 8'h99);
    checks++; if (o_wr !== 0) begin errors++; $display("FAIL ro_no_write: got %0d wr cycles exp 0", o_wr); end
    checks++; if (o_gout !== exp_gout()) begin errors++; $display("FAIL ro_readback: got %h exp %h", o_gout, exp_gout()); end
    checks++; if (o_cnt !== m_count) begin errors++; $display("FAIL ro_count: got %h exp %h", o_cnt, m_count); end
    foreach (bnd[i]) begin
      drive_txn(bnd[i], 8'($urandom));
      checks++; if (o_wr != (is_ro(bnd[i]) ? 0 : 1) || o_gout !== exp_gout()) begin errors++;
        $display("FAIL ro_boundary a=%h: wr %0d gout %h exp wr %0d gout %h", bnd[i], o_wr, o_gout, is_ro(bnd[i]) ? 0 : 1, exp_gout()); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    for (int n = 0; n < 25; n++) begin
      a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      d = 8'($urandom);
      drive_txn(a, d);
      checks++;
      if (o_wr != (is_ro(a) ? 0 : 1) || o_addr !== a || o_data !== d || o_raddr !== a ||
          o_gout !== exp_gout() || o_cnt !== m_count || o_adc !== m_adc ||
          o_run != ((!is_ro(a) && a == 0) ? 1 : 0) || o_del != ((a == 1) ? 1 : 0) ||
          o_halt != ((a == 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL random a=%h d=%h: wr %0d addr %h data %h gout %h cnt %h adc %b pulses %0d%0d%0d exp gout %h cnt %h adc %b",
                 a, d, o_wr, o_addr, o_data, o_gout, o_cnt, o_adc, o_run, o_del, o_halt, exp_gout(), m_count, m_adc);
      end
    end
  endtask

  task automatic test_strobe_through_reset();
    int w = 0;
    @(negedge clk); gpio_in = {7'd0, 1'b1, 8'h5A, 16'h000C};
    do_reset(3);
    for (int k = 0; k < 8; k++) begin @(negedge clk); w += int'(wr_en); end
    checks++; if (w != 0 || gpio_out !== 32'd0 || txn_count !== 16'd0) begin errors++;
      $display("FAIL held_strobe: wr %0d gout %h cnt %h exp 0 0 0", w, gpio_out, txn_count); end
    gpio_in[24] = 1'b0;
    repeat (4) @(negedge clk);
    drive_txn(16'h0003, 8'h77);
    checks++; if (o_wr != 1 || o_cnt !== 16'd1 || o_gout !== 32'h0000_0177) begin errors++;
      $display("FAIL held_then_txn: wr %0d cnt %h gout %h exp 1 0001 00000177", o_wr, o_cnt, o_gout); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    release dut.cnt_q;
    m_count = 16'hFFFF;
    drive_txn(16'h000D, 8'h11);
    checks++; if (o_cnt !== 16'h0000 || o_wr != 1) begin errors++; $display("FAIL count_wrap: got %h wr %0d exp 0000 1", o_cnt, o_wr); end
    drive_txn(16'h0013, 8'h22);
    checks++; if (o_cnt !== 16'h0001 || o_wr != 0) begin errors++; $display("FAIL wrap_then_ro: got %h wr %0d exp 0001 0", o_cnt, o_wr); end
  endtask

  task automatic test_reset_mid_txn();
    int w = 0;
    drive_txn(16'h0005, 8'h01);
    @(negedge clk); gpio_in = {7'd0, 1'b0, 8'hC3, 16'h000E};
    repeat (3) @(negedge clk);
    gpio_in[24] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++; if ({gpio_out, wr_addr, wr_data, rd_addr, txn_count, wr_en, run_trig, del_trig, halt, adc_run} !== 93'd0) begin errors++;
      $display("FAIL mid_reset_values: gout %h addr %h data %h cnt %h adc %b wr %b exp all 0", gpio_out, wr_addr, wr_data, txn_count, adc_run, wr_en); end
    for (int k = 0; k < 6; k++) begin @(negedge clk); w += int'(wr_en); end
    checks++; if (w != 0 || gpio_out !== 32'd0 || txn_count !== 16'd0) begin errors++;
      $display("FAIL mid_reset_abort: wr %0d gout %h cnt %h exp 0 0 0", w, gpio_out, txn_count); end
    gpio_in[24] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    gpio_in = 32'd0;
    model_reset();
    for (int i = 0; i < 32; i++) ro_val[i] = 8'($urandom);
    test_reset();
    test_basic_write();
    test_pulses();
    test_adc_run();
    test_readonly();
    test_random();
    test_strobe_through_reset();
    test_wrap();
    test_reset_mid_txn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
